// File: rtl/arbiter_rr_split.sv
// N-master round-robin bus arbiter with split-transaction parking and a bounded grant tenure.
// Latency: a request seen in IDLE is granted on the next edge; every owner change inserts exactly one dead cycle.
// Backpressure: masters hold breq until served; a split owner is parked (masked) until its split_done pulse.
// Optional: define ARB_TENURE_LIMIT_EN to build the tenure counter and force handover after MAX_TENURE cycles.
module arbiter_rr_split #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_TENURE  = 16,
  localparam int ID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   split,
  input  logic [NUM_MASTERS-1:0] split_done,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [ID_W-1:0]        owner_id,
  output logic                   bus_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HANDOVER} state_t;

  // Reject unsupported configurations at elaboration time.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_TENURE < 2) begin : g_bad_param
    $error("arbiter_rr_split: NUM_MASTERS must be 2..8 and MAX_TENURE >= 2");
  end

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] bgrant_q;
  logic [ID_W-1:0]        owner_q;
  logic [ID_W-1:0]        last_owner_q;
  logic                   bus_busy_q;
  logic [NUM_MASTERS-1:0] split_mask_q;
  logic [NUM_MASTERS-1:0] split_mask_d;
  logic [NUM_MASTERS-1:0] split_set;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_vld;
  logic [ID_W-1:0]        pick_idx;
  logic [ID_W-1:0]        cand;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   tenure_hit;

  // Parked masters are invisible to arbitration until their slave reports ready.
  assign eligible = breq & ~split_mask_q;

  // Only a split seen while a master owns the bus parks that owner; a set beats a same-cycle clear.
  assign split_set    = (state_q == S_GRANT && split) ? bgrant_q : '0;
  assign split_mask_d = (split_mask_q & ~split_done) | split_set;

  // Round-robin search starting just above the previous owner; the nearest candidate is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = ID_W'((int'(last_owner_q) + k) % NUM_MASTERS);
      if (eligible[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_oh = NUM_MASTERS'(1) << pick_idx;

`ifdef ARB_TENURE_LIMIT_EN
  localparam int TEN_W = $clog2(MAX_TENURE + 1);
  logic [TEN_W-1:0] tenure_q;
  logic [TEN_W-1:0] tenure_d;

  // Tenure expiry only forces handover when someone else is actually waiting.
  assign tenure_hit = (tenure_q == TEN_W'(MAX_TENURE)) && ((eligible & ~bgrant_q) != '0);

  // Count granted cycles, saturating so a sole requester simply keeps the bus.
  always_comb begin
    tenure_d = tenure_q;
    if (state_q != S_GRANT) begin
      tenure_d = TEN_W'(1);
    end else if (tenure_q != TEN_W'(MAX_TENURE)) begin
      tenure_d = tenure_q + TEN_W'(1);
    end
  end

  // Tenure register; the value loaded while not granting is the count for the first granted cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tenure_q <= '0;
    end else begin
      tenure_q <= tenure_d;
    end
  end
`else
  assign tenure_hit = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner and busy outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bgrant_q     <= '0;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_MASTERS - 1);
      bus_busy_q   <= 1'b0;
      split_mask_q <= '0;
    end else begin
      split_mask_q <= split_mask_d;
      case (state_q)
        S_IDLE, S_HANDOVER: begin
          if (pick_vld) begin
            state_q    <= S_GRANT;
            bgrant_q   <= pick_oh;
            owner_q    <= pick_idx;
            bus_busy_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (split || !breq[owner_q] || tenure_hit) begin
            state_q      <= S_HANDOVER;
            bgrant_q     <= '0;
            bus_busy_q   <= 1'b0;
            last_owner_q <= owner_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          bgrant_q   <= '0;
          bus_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bgrant   = bgrant_q;
  assign owner_id = owner_q;
  assign bus_busy = bus_busy_q;

  // Grant is one-hot or idle, and ownership never jumps without a dead cycle.
  a_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bgrant_q));
  a_no_direct_swap: assert property (@(posedge clk) disable iff (!rstn)
    ((|bgrant_q) && (|$past(bgrant_q))) |-> (bgrant_q == $past(bgrant_q)));
  a_owner_match: assert property (@(posedge clk) disable iff (!rstn)
    bus_busy_q |-> (bgrant_q[owner_q] && (bus_busy_q == (|bgrant_q))));

endmodule

// File: tb/tb_arbiter_rr_split.sv
// Directed bench for arbiter_rr_split: a 2-master instance (default tenure) and a 4-master instance (MAX_TENURE=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Cycle 0 is the first cycle after reset release.
module tb_arbiter_rr_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [1:0] breq2, sd2, bg2;
  logic       split2, busy2;
  logic [0:0] oid2;
  logic [3:0] breq4, sd4, bg4;
  logic       split4, busy4;
  logic [1:0] oid4;

  int checks = 0;
  int errors = 0;

  arbiter_rr_split #(.NUM_MASTERS(2)) u_arb2 (
    .clk(clk), .rstn(rstn), .breq(breq2), .split(split2), .split_done(sd2),
    .bgrant(bg2), .owner_id(oid2), .bus_busy(busy2)
  );

  arbiter_rr_split #(.NUM_MASTERS(4), .MAX_TENURE(4)) u_arb4 (
    .clk(clk), .rstn(rstn), .breq(breq4), .split(split4), .split_done(sd4),
    .bgrant(bg4), .owner_id(oid4), .bus_busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, then release so that the current cycle is cycle 0.
  task automatic reset_release();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    breq2 = 2'b11; split2 = 1'b0; sd2 = 2'b00;
    rstn = 1'b0;
    step();
    checks++;
    if (bg2 !== 2'b00 || busy2 !== 1'b0 || oid2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bgrant=%b busy=%b owner=%0d, expected 00/0/0", bg2, busy2, oid2);
    end
    step();
    rstn = 1'b1;
    checks++;
    if (bg2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_c0: bgrant=%b expected 00", bg2);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      case (c)
        1, 2, 3, 4, 5: exp = 2'b01;
        6:             exp = 2'b00;
        default:       exp = 2'b10;
      endcase
      checks++;
      if (bg2 !== exp || busy2 !== (exp != 2'b00) || (exp != 2'b00 && oid2 !== (exp == 2'b10))) begin
        errors++;
        $display("FAIL reset_seq c%0d: bgrant=%b busy=%b owner=%0d, expected bgrant=%b", c, bg2, busy2, oid2, exp);
      end
      if (c == 5) breq2 = 2'b10;
    end
    breq2 = 2'b00;
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    logic [3:0] one;
    int         eid;
    one = 4'b0001;
    breq4 = 4'b1111; split4 = 1'b0; sd4 = 4'b0000;
    reset_release();
`ifdef ARB_TENURE_LIMIT_EN
    // Every master holds its request; MAX_TENURE=4 forces 4-cycle grants with one dead cycle between.
    for (int c = 1; c <= 24; c++) begin
      step();
      if ((c - 1) % 5 == 4) begin
        exp = 4'b0000;
        eid = 0;
      end else begin
        eid = ((c - 1) / 5) % 4;
        exp = one << eid;
      end
      checks++;
      if (bg4 !== exp || busy4 !== (exp != 4'b0000) || (exp != 4'b0000 && oid4 !== 2'(eid))) begin
        errors++;
        $display("FAIL rotation c%0d: bgrant=%b owner=%0d, expected bgrant=%b owner=%0d", c, bg4, oid4, exp, eid);
      end
    end
`else
    // Without a tenure limit the owner keeps the bus; dropping each owner's request walks the round robin.
    for (int c = 1; c <= 20; c++) begin
      step();
      case (c)
        1, 2, 3, 4, 5, 6, 7, 8, 20: begin exp = 4'b0001; eid = 0; end
        10, 11, 12:                 begin exp = 4'b0010; eid = 1; end
        14, 15:                     begin exp = 4'b0100; eid = 2; end
        17, 18:                     begin exp = 4'b1000; eid = 3; end
        default:                    begin exp = 4'b0000; eid = 0; end
      endcase
      checks++;
      if (bg4 !== exp || busy4 !== (exp != 4'b0000) || (exp != 4'b0000 && oid4 !== 2'(eid))) begin
        errors++;
        $display("FAIL rotation c%0d: bgrant=%b owner=%0d, expected bgrant=%b owner=%0d", c, bg4, oid4, exp, eid);
      end
      case (c)
        8:  breq4 = 4'b1110;
        12: breq4 = 4'b1101;
        15: breq4 = 4'b1011;
        18: breq4 = 4'b0111;
        9, 13, 16, 19: breq4 = 4'b1111;
        default: ;
      endcase
    end
`endif
    breq4 = 4'b0000;
  endtask

  task automatic test_single_requester();
    breq2 = 2'b10; split2 = 1'b0; sd2 = 2'b00;
    reset_release();
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (bg2 !== 2'b10 || busy2 !== 1'b1 || oid2 !== 1'b1) begin
        errors++;
        $display("FAIL single_req c%0d: bgrant=%b busy=%b owner=%0d, expected 10/1/1", c, bg2, busy2, oid2);
      end
    end
    breq2 = 2'b00;
  endtask

  task automatic test_split();
    logic [1:0] exp;
    breq2 = 2'b11; split2 = 1'b0; sd2 = 2'b00;
    reset_release();
    for (int c = 1; c <= 15; c++) begin
      step();
      case (c)
        1, 2, 3, 14, 15: exp = 2'b01;
        4, 13:           exp = 2'b00;
        default:         exp = 2'b10;
      endcase
      checks++;
      if (bg2 !== exp || busy2 !== (exp != 2'b00)) begin
        errors++;
        $display("FAIL split c%0d: bgrant=%b busy=%b, expected bgrant=%b", c, bg2, busy2, exp);
      end
      split2 = (c == 3);
      sd2    = (c == 10) ? 2'b01 : 2'b00;
      if (c == 12) breq2 = 2'b01;
    end
    breq2 = 2'b00;
  endtask

  task automatic test_split_same_cycle();
    logic [1:0] exp;
    breq2 = 2'b11; split2 = 1'b0; sd2 = 2'b00;
    reset_release();
    for (int c = 1; c <= 15; c++) begin
      step();
      case (c)
        1, 2, 10, 11, 12, 13: exp = 2'b01;
        4, 5, 15:             exp = 2'b10;
        default:              exp = 2'b00;
      endcase
      checks++;
      if (bg2 !== exp || busy2 !== (exp != 2'b00)) begin
        errors++;
        $display("FAIL split_same c%0d: bgrant=%b busy=%b, expected bgrant=%b", c, bg2, busy2, exp);
      end
      // c2: split and split_done[0] together; c7: split while idle; c11: split_done for an unmasked master.
      split2 = (c == 2) || (c == 7);
      case (c)
        2, 8:    sd2 = 2'b01;
        11:      sd2 = 2'b10;
        default: sd2 = 2'b00;
      endcase
      case (c)
        5:  breq2 = 2'b01;
        12: breq2 = 2'b11;
        13: breq2 = 2'b10;
        default: ;
      endcase
    end
    breq2 = 2'b00; split2 = 1'b0; sd2 = 2'b00;
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    breq2 = 2'b11; split2 = 1'b0; sd2 = 2'b00;
    reset_release();
    for (int c = 1; c <= 5; c++) begin
      step();
      case (c)
        1, 2, 3: exp = 2'b01;
        4:       exp = 2'b00;
        default: exp = 2'b10;
      endcase
      checks++;
      if (bg2 !== exp) begin
        errors++;
        $display("FAIL async_pre c%0d: bgrant=%b expected %b", c, bg2, exp);
      end
      split2 = (c == 3);
    end
    // Master 1 owns the bus and master 0 is parked; pull reset between edges.
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (bg2 !== 2'b00 || busy2 !== 1'b0 || oid2 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: bgrant=%b busy=%b owner=%0d, expected 00/0/0", bg2, busy2, oid2);
    end
    step();
    step();
    rstn = 1'b1;
    checks++;
    if (bg2 !== 2'b00) begin
      errors++;
      $display("FAIL async_c0: bgrant=%b expected 00", bg2);
    end
    step();
    checks++;
    if (bg2 !== 2'b01 || oid2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL async_regrant: bgrant=%b owner=%0d busy=%b, expected 01/0/1", bg2, oid2, busy2);
    end
    breq2 = 2'b00;
  endtask

  initial begin
    rstn = 1'b0;
    breq2 = 2'b00; split2 = 1'b0; sd2 = 2'b00;
    breq4 = 4'b0000; split4 = 1'b0; sd4 = 4'b0000;
    test_reset();
    test_rotation();
    test_single_requester();
    test_split();
    test_split_same_cycle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
